mem_port_arbiter: RTL

- Sits directly below the pipeline datapath.
- Takes the pipeline's two memory ports (IF instruction port, MEM data port) and merges them onto one physical memory/L2 port.
- Grants one client at a time and latches the request for the whole transaction. Returns the downstream response to the granted client only.
- Priority goes to the MEM stage. A bounded streak counter keeps instruction fetch from starving.

---
 rtl/mem_port_arbiter_pkg.sv | 59 +++++
 rtl/arb_req_latch.sv | 25 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state, latched request
// record and small helpers used by the arbitration logic.
package mem_port_arbiter_pkg;

    localparam int unsigned LC3B_WORD_W = 16;
    localparam int unsigned BE_W        = 2;
    localparam int unsigned STREAK_W    = 4;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [BE_W-1:0]        lc3b_be;
    typedef logic [STREAK_W-1:0]    streak_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IF  = 2'd1,
        SERVE_MEM = 2'd2
    } arb_state_t;

    typedef struct packed {
        lc3b_word addr;
        lc3b_word wdata;
        lc3b_be   byte_enable;
        logic     read;
        logic     write;
    } lc3b_mem_req;

    localparam lc3b_mem_req REQ_CLEAR = '0;

    // A simultaneous read+write from MEM is illegal; the write is kept.
    function automatic lc3b_mem_req make_mem_req(input lc3b_word addr,
                                                 input lc3b_word wdata,
                                                 input lc3b_be   byte_enable,
                                                 input logic     read,
                                                 input logic     write);
        lc3b_mem_req r;
        r.addr        = addr;
        r.wdata       = wdata;
        r.byte_enable = byte_enable;
        r.read        = read & ~write;
        r.write       = write;
        return r;
    endfunction

    function automatic lc3b_mem_req make_if_req(input lc3b_word addr,
                                                input lc3b_be   byte_enable);
        lc3b_mem_req r;
        r.addr        = addr;
        r.wdata       = '0;
        r.byte_enable = byte_enable;
        r.read        = 1'b1;
        r.write       = 1'b0;
        return r;
    endfunction

    function automatic streak_t streak_inc(input streak_t cur, input streak_t max);
        return (cur >= max) ? max : cur + streak_t'(1);
    endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Load-enabled holding register for the granted memory request; the
// downstream port is driven only from this copy while a transaction runs.
module arb_req_latch
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  lc3b_mem_req d,
    output lc3b_mem_req q
);

    lc3b_mem_req req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= REQ_CLEAR;
        end else if (load) begin
            req_q <= d;
        end
    end

    assign q = req_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the pipeline IF and MEM memory ports onto a single downstream port.
// MEM has priority; a saturating streak counter forces IF through eventually.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_MEM_STREAK = 4,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] if_memaddr,
    input  logic              if_memread,
    input  logic [1:0]        if_mem_byte_enable,
    output logic              if_mem_resp,
    output logic [DATA_W-1:0] if_mem_rdata,

    input  logic [ADDR_W-1:0] mem_memaddr,
    input  logic              mem_memread,
    input  logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_mem_wdata,
    input  logic [1:0]        mem_mem_byte_enable,
    output logic              mem_mem_resp,
    output logic [DATA_W-1:0] mem_mem_rdata,

    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [1:0]        pmem_byte_enable,
    input  logic              pmem_resp,
    input  logic [DATA_W-1:0] pmem_rdata
);

    localparam streak_t STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

    arb_state_t  state_q;
    streak_t     streak_q;
    lc3b_mem_req req_d;
    lc3b_mem_req req_q;

    logic mem_req;
    logic if_req;
    logic grant_mem;
    logic grant_if;
    logic serving;
    logic resp_if;
    logic resp_mem;

    assign mem_req = mem_memread | mem_memwrite;
    assign if_req  = if_memread;

    always_comb begin
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if (state_q == IDLE) begin
            if (mem_req && (!if_req || (streak_q < STREAK_MAX))) begin
                grant_mem = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        req_d = REQ_CLEAR;
        if (grant_mem) begin
            req_d = make_mem_req(mem_memaddr, mem_mem_wdata, mem_mem_byte_enable,
                                 mem_memread, mem_memwrite);
        end else if (grant_if) begin
            req_d = make_if_req(if_memaddr, if_mem_byte_enable);
        end
    end

    arb_req_latch u_req_latch (
        .clk   (clk),
        .reset (reset),
        .load  (grant_mem | grant_if),
        .d     (req_d),
        .q     (req_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_mem) begin
                        state_q  <= SERVE_MEM;
                        streak_q <= if_req ? streak_inc(streak_q, STREAK_MAX) : '0;
                    end else if (grant_if) begin
                        state_q  <= SERVE_IF;
                        streak_q <= '0;
                    end else begin
                        // No grant means no IF request is pending either.
                        streak_q <= '0;
                    end
                end
                SERVE_IF, SERVE_MEM: begin
                    if (pmem_resp) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign serving = (state_q == SERVE_IF) || (state_q == SERVE_MEM);

    assign pmem_address     = req_q.addr;
    assign pmem_wdata       = req_q.wdata;
    assign pmem_byte_enable = req_q.byte_enable;
    assign pmem_read        = serving & req_q.read;
    assign pmem_write       = serving & req_q.write;

    // Gated by reset so an in-flight completion is dropped, not delivered.
    assign resp_if  = (state_q == SERVE_IF)  & pmem_resp & ~reset;
    assign resp_mem = (state_q == SERVE_MEM) & pmem_resp & ~reset;

    assign if_mem_resp   = resp_if;
    assign mem_mem_resp  = resp_mem;
    assign if_mem_rdata  = resp_if  ? pmem_rdata : '0;
    assign mem_mem_rdata = resp_mem ? pmem_rdata : '0;

endmodule
